// File: rtl/cell_func_checker_if.sv
// rtl/cell_func_checker_if.sv - handshake/status bundle between a checker and its driver
//
// Purpose: groups the run control, cell stimulus/response and result status
//          of cell_func_checker so that one port carries them.
// Signals:
//   START      run request (driver -> checker)
//   MODE[1:0]  golden function select (driver -> checker)
//   Y_IN       output of the cell under test (driver -> checker)
//   A0/A1/B    stimulus to the cell (checker -> driver)
//   BUSY       vectors are being applied
//   DONE       sticky completion flag
//   PASS       DONE with zero mismatches
//   ERR_CNT    saturating mismatch count
//   FAIL_VALID first mismatch captured
//   FAIL_VEC   vector of the first mismatch
interface cell_func_checker_if #(
  parameter int ERRW = 4
);
  logic            START;
  logic [1:0]      MODE;
  logic            Y_IN;
  logic            A0;
  logic            A1;
  logic            B;
  logic            BUSY;
  logic            DONE;
  logic            PASS;
  logic [ERRW-1:0] ERR_CNT;
  logic            FAIL_VALID;
  logic [2:0]      FAIL_VEC;

  modport master (
    output START, MODE, Y_IN,
    input  A0, A1, B, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC
  );

  modport slave (
    input  START, MODE, Y_IN,
    output A0, A1, B, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC
  );
endinterface

// File: rtl/cell_func_checker.sv
// rtl/cell_func_checker.sv - exhaustive stimulus/response checker for 3-input inverting cells
//
// Purpose: walks A0/A1/B through all 8 vectors, holds each for SETTLE+1
//          cycles, samples the cell output at the last edge of the window and
//          compares it with the golden function chosen by MODE at START.
// Ports:
//   CLK  clock, rising edge
//   RN   asynchronous active-low reset
//   bus  slave side of cell_func_checker_if (START/MODE/Y_IN in,
//        A0/A1/B, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC out)
module cell_func_checker #(
  parameter int SETTLE = 2,
  parameter int ERRW   = 4
) (
  input  logic                CLK,
  input  logic                RN,
  cell_func_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t          state_q;
  logic [2:0]      vec_q;
  logic [3:0]      cnt_q;
  logic [1:0]      mode_q;
  logic [ERRW-1:0] err_q;
  logic            fail_valid_q;
  logic [2:0]      fail_vec_q;
  logic            done_q;

  logic            exp_y;
  logic            mismatch;

  function automatic logic golden(input logic [1:0] m, input logic [2:0] v);
    logic y;
    case (m)
      2'd0:    y = ~((v[0] & v[1]) | v[2]);   // AOI21
      2'd1:    y = ~((v[0] | v[1]) & v[2]);   // OAI21
      2'd2:    y = ~(&v);                     // NAND3
      default: y = ~(|v);                     // NOR3
    endcase
    return y;
  endfunction

  assign exp_y    = golden(mode_q, vec_q);
  assign mismatch = (bus.Y_IN != exp_y);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      mode_q       <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            mode_q       <= bus.MODE;
            vec_q        <= '0;
            cnt_q        <= SETTLE_C;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            done_q       <= 1'b0;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Y_IN is only looked at here, at the end of the settle window.
            if (mismatch) begin
              if (err_q != {ERRW{1'b1}}) begin
                err_q <= err_q + 1'b1;
              end
              if (!fail_valid_q) begin
                fail_valid_q <= 1'b1;
                fail_vec_q   <= vec_q;
              end
            end
            if (vec_q == 3'd7) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              vec_q <= vec_q + 3'd1;
              cnt_q <= SETTLE_C;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stimulus is gated so the cell inputs rest at 0 outside a run.
  assign bus.BUSY       = (state_q == ST_RUN);
  assign bus.A0         = bus.BUSY & vec_q[0];
  assign bus.A1         = bus.BUSY & vec_q[1];
  assign bus.B          = bus.BUSY & vec_q[2];
  assign bus.DONE       = done_q;
  assign bus.PASS       = done_q && (err_q == '0);
  assign bus.ERR_CNT    = err_q;
  assign bus.FAIL_VALID = fail_valid_q;
  assign bus.FAIL_VEC   = fail_vec_q;

endmodule

// File: doc/cell_func_checker.md
Name: cell_func_checker

Overview:
- Sequential stimulus/response checker sitting at the other end of a 3-input inverting standard cell (AOI21, OAI21, NAND3, NOR3) in the gp12t3v3 library.
- Drives A0/A1/B through all 8 input vectors and samples the cell's Y after a programmable settle time.
- Compares each sample against a built-in golden function and reports the error count, the first failing vector and pass/done status.
- Used in silicon test structures and in library-level regression benches.

Parameters:
SETTLE, 2, cycles the checker waits after applying a vector before it samples Y (0..15)
ERRW, 4, width of the saturating error counter

Ports:
CLK  input  1  clock, rising edge
RN  input  1  asynchronous active-low reset
START  input  1  run request; sampled in IDLE or DONE only
MODE  input  2  golden function select: 0 AOI21 Y=~((A0&A1)|B), 1 OAI21 Y=~((A0|A1)&B), 2 NAND3, 3 NOR3
Y_IN  input  1  output of the cell under test
A0  output  1  stimulus, equals vec[0]
A1  output  1  stimulus, equals vec[1]
B  output  1  stimulus, equals vec[2]
BUSY  output  1  high while vectors are being applied
DONE  output  1  sticky completion flag
PASS  output  1  DONE && ERR_CNT==0
ERR_CNT  output  ERRW  number of mismatches, saturating
FAIL_VALID  output  1  at least one mismatch has been captured
FAIL_VEC  output  3  vec value of the first mismatch

Behaviour:
- Reset (RN low, async): state IDLE, vec=0, cnt=0. All outputs are 0 immediately, with no clock needed. This applies mid-run too.
- States: IDLE, RUN, DONE. A0/A1/B are driven from vec in RUN only and are forced to 0 in IDLE and DONE.
- START in IDLE or DONE (sampled at a rising edge):
  - latch MODE into mode_q; vec<=0, cnt<=SETTLE
  - clear ERR_CNT, FAIL_VALID, FAIL_VEC and DONE
  - go to RUN
- START while in RUN is ignored. A MODE change during RUN has no effect.
- RUN, every cycle:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0 (sample cycle): compare Y_IN with expected(mode_q, vec).
  - On mismatch: ERR_CNT<=ERR_CNT+1, saturating at 2^ERRW-1. If FAIL_VALID==0, set FAIL_VALID<=1 and FAIL_VEC<=vec.
  - If vec==7, go to DONE. Otherwise vec<=vec+1 and cnt<=SETTLE.
- Each vector is held for SETTLE+1 cycles; Y_IN is sampled at the final edge of that window.
- Total BUSY time is 8*(SETTLE+1) cycles. DONE rises at the edge after the vec=7 sample. With SETTLE=0 this is 8 cycles.
- DONE stays high until the next accepted START or reset. PASS is combinational from DONE and ERR_CNT.
- BUSY equals (state==RUN).
- vec does not wrap: 7 is terminal, and DONE does not auto-restart.
- Y_IN is used only on sample cycles. X on Y_IN at other cycles is ignored. The module provides no synchroniser; the bench and the cell must meet setup timing via SETTLE.

Test Plan:
- Golden AOI21 model on Y_IN, SETTLE=2, MODE=0, START pulse -> BUSY for 24 cycles; A0/A1/B step 0..7 every 3 cycles; DONE=1, PASS=1, ERR_CNT=0, FAIL_VALID=0.
- Y_IN tied 0, MODE=0 -> mismatches at vec 0,1,2 -> ERR_CNT=3, FAIL_VEC=0, FAIL_VALID=1, PASS=0.
- Y_IN tied 1, MODE=0, ERRW=2 -> mismatches at vec 3..7, 5 errors -> ERR_CNT saturates at 3, FAIL_VEC=3.
- OAI21 model connected but MODE=0 -> mismatches at vec 3 and 4 only -> ERR_CNT=2, FAIL_VEC=3. Rerun with MODE=1 and a START from DONE -> counters cleared, PASS=1.
- RN pulled low 10 cycles into a run -> BUSY, DONE, A0/A1/B, ERR_CNT all 0 immediately. After RN releases, the checker stays in IDLE until a new START.
- START re-pulsed while BUSY, plus MODE toggled mid-run -> no restart; run completes on the original 24-cycle schedule with mode latched at START.
